// File: rtl/la_arb3x2_pkg.sv
// Shared types and sizes for the 3-requester / 2-unit round-robin arbiter.
package la_arb3x2_pkg;

  localparam int unsigned NREQ  = 3;
  localparam int unsigned NUNIT = 2;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } unit_state_e;

  // Requester index arithmetic modulo NREQ; operands are always < NREQ.
  function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] base,
                                               input logic [IDX_W-1:0] step);
    logic [IDX_W:0] sum;
    sum = {1'b0, base} + {1'b0, step};
    return (sum >= 3'(NREQ)) ? IDX_W'(sum - 3'(NREQ)) : IDX_W'(sum);
  endfunction

endpackage

// File: rtl/la_arb3x2_pick.sv
// Rotate-priority picker: first and second pending requesters scanning from ptr.
module la_arb3x2_pick
  import la_arb3x2_pkg::*;
(
  input  logic [NREQ-1:0]  pend,
  input  logic [IDX_W-1:0] ptr,
  output logic             first_vld_c,
  output logic [IDX_W-1:0] first_idx_c,
  output logic             second_vld_c,
  output logic [IDX_W-1:0] second_idx_c
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    first_vld_c  = 1'b0;
    first_idx_c  = '0;
    second_vld_c = 1'b0;
    second_idx_c = '0;
    idx          = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = idx_add(ptr, IDX_W'(i));
      if (pend[idx]) begin
        if (!first_vld_c) begin
          first_vld_c = 1'b1;
          first_idx_c = idx;
        end else if (!second_vld_c) begin
          second_vld_c = 1'b1;
          second_idx_c = idx;
        end
      end
    end
  end

endmodule

// File: rtl/la_arb3x2.sv
// Round-robin arbiter sharing two resource units among three requesters.
// Optional hold timeout enabled by defining LA_ARB3X2_TIMEOUT_EN.
module la_arb3x2
  import la_arb3x2_pkg::*;
#(
  parameter string       PROP    = "DEFAULT",
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  rel,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  gnt_unit,
  output logic [NUNIT-1:0] busy,
  output logic             avail,
  output logic [NREQ-1:0]  tmo
);

  unit_state_e      st_q  [NUNIT];
  unit_state_e      st_d  [NUNIT];
  logic [IDX_W-1:0] own_q [NUNIT];
  logic [IDX_W-1:0] own_d [NUNIT];
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_d, gnt_unit_d, tmo_d;
  logic [NUNIT-1:0] busy_d;
  logic             avail_d;
  logic [NREQ-1:0]  pend;
  logic             first_unit;
  logic             first_vld_c, second_vld_c;
  logic [IDX_W-1:0] first_idx_c, second_idx_c;
  logic             unused_cfg;

`ifdef LA_ARB3X2_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q [NUNIT];
  logic [CNT_W-1:0] cnt_d [NUNIT];
  assign unused_cfg = (PROP == "");
`else
  assign unused_cfg = (PROP == "") | (TIMEOUT == 0);
`endif

  assign pend    = req & ~gnt;
  assign avail_d = (|pend) & (|(~busy));

  la_arb3x2_pick u_pick (
    .pend         (pend),
    .ptr          (ptr_q),
    .first_vld_c  (first_vld_c),
    .first_idx_c  (first_idx_c),
    .second_vld_c (second_vld_c),
    .second_idx_c (second_idx_c)
  );

  // Releases act on units busy now; grants only use units already idle now.
  always_comb begin
    st_d       = st_q;
    own_d      = own_q;
    ptr_d      = ptr_q;
    tmo_d      = '0;
    gnt_d      = '0;
    gnt_unit_d = '0;
    busy_d     = '0;
    first_unit = 1'b0;
`ifdef LA_ARB3X2_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    for (int k = 0; k < NUNIT; k++) begin
      if (st_q[k] == BUSY) begin
        if (rel[own_q[k]]) begin
          st_d[k] = IDLE;
`ifdef LA_ARB3X2_TIMEOUT_EN
        end else if (cnt_q[k] == HOLD_LAST) begin
          st_d[k]             = IDLE;
          tmo_d[own_q[k]]     = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
`endif
        end
      end
    end
    if (first_vld_c && (st_q[0] == IDLE || st_q[1] == IDLE)) begin
      first_unit        = (st_q[0] == IDLE) ? 1'b0 : 1'b1;
      st_d[first_unit]  = BUSY;
      own_d[first_unit] = first_idx_c;
      ptr_d             = idx_add(first_idx_c, IDX_W'(1));
`ifdef LA_ARB3X2_TIMEOUT_EN
      cnt_d[first_unit] = '0;
`endif
      if (second_vld_c && st_q[0] == IDLE && st_q[1] == IDLE) begin
        st_d[1]  = BUSY;
        own_d[1] = second_idx_c;
        ptr_d    = idx_add(second_idx_c, IDX_W'(1));
`ifdef LA_ARB3X2_TIMEOUT_EN
        cnt_d[1] = '0;
`endif
      end
    end
    for (int k = 0; k < NUNIT; k++) begin
      if (st_d[k] == BUSY) begin
        busy_d[k]            = 1'b1;
        gnt_d[own_d[k]]      = 1'b1;
        gnt_unit_d[own_d[k]] = 1'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= '{default: IDLE};
      own_q    <= '{default: '0};
      ptr_q    <= '0;
      gnt      <= '0;
      gnt_unit <= '0;
      busy     <= '0;
      avail    <= 1'b0;
      tmo      <= '0;
`ifdef LA_ARB3X2_TIMEOUT_EN
      cnt_q    <= '{default: '0};
`endif
    end else begin
      st_q     <= st_d;
      own_q    <= own_d;
      ptr_q    <= ptr_d;
      gnt      <= gnt_d;
      gnt_unit <= gnt_unit_d;
      busy     <= busy_d;
      avail    <= avail_d;
      tmo      <= tmo_d;
`ifdef LA_ARB3X2_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_la_arb3x2.sv
// Bench for la_arb3x2: directed scenarios plus random traffic against an ownership-table model.
module tb_la_arb3x2;

  localparam int unsigned TMO = 4;
`ifdef LA_ARB3X2_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] req = '0;
  logic [2:0] rel = '0;
  logic [2:0] gnt, gnt_unit, tmo;
  logic [1:0] busy;
  logic       avail;

  int checks = 0;
  int errors = 0;

  // Model: which requester owns each unit (-1 = free), hold cycles, rotation pointer.
  int         m_own [2];
  int         m_hold[2];
  int         m_ptr;
  logic [2:0] e_tmo;
  logic       e_avail;

  always #5 clk = ~clk;

  la_arb3x2 #(.TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .rel      (rel),
    .gnt      (gnt),
    .gnt_unit (gnt_unit),
    .busy     (busy),
    .avail    (avail),
    .tmo      (tmo)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k]  = -1;
      m_hold[k] = 0;
    end
    m_ptr   = 0;
    e_tmo   = '0;
    e_avail = 1'b0;
  endtask

  task automatic model_edge(input logic [2:0] r, input logic [2:0] rl);
    int         nown[2];
    int         freel[$];
    int         pendq[$];
    logic [2:0] gnow;
    int         u, j;
    gnow = '0;
    for (int k = 0; k < 2; k++) if (m_own[k] >= 0) gnow[m_own[k]] = 1'b1;
    e_avail = ((r & ~gnow) != 3'b000) && (m_own[0] < 0 || m_own[1] < 0);
    e_tmo = '0;
    nown  = m_own;
    for (int k = 0; k < 2; k++) begin
      if (m_own[k] >= 0) begin
        if (rl[m_own[k]]) nown[k] = -1;
        else if (TMO_EN && m_hold[k] == int'(TMO) - 1) begin
          e_tmo[m_own[k]] = 1'b1;
          nown[k] = -1;
        end else m_hold[k]++;
      end
    end
    for (int k = 0; k < 2; k++) if (m_own[k] < 0) freel.push_back(k);
    for (int i = 0; i < 3; i++) begin
      j = (m_ptr + i) % 3;
      if (r[j] && !gnow[j]) pendq.push_back(j);
    end
    while (freel.size() > 0 && pendq.size() > 0) begin
      u = freel.pop_front();
      j = pendq.pop_front();
      nown[u]   = j;
      m_hold[u] = 0;
      m_ptr     = (j + 1) % 3;
    end
    m_own = nown;
  endtask

  task automatic check_all(input string tag);
    logic [2:0] eg, eu;
    logic [1:0] eb;
    eg = '0; eu = '0; eb = '0;
    for (int k = 0; k < 2; k++) begin
      if (m_own[k] >= 0) begin
        eg[m_own[k]] = 1'b1;
        eb[k] = 1'b1;
        if (k == 1) eu[m_own[k]] = 1'b1;
      end
    end
    check({tag, ".gnt"},      32'(gnt),      32'(eg));
    check({tag, ".gnt_unit"}, 32'(gnt_unit), 32'(eu));
    check({tag, ".busy"},     32'(busy),     32'(eb));
    check({tag, ".avail"},    32'(avail),    32'(e_avail));
    check({tag, ".tmo"},      32'(tmo),      32'(e_tmo));
  endtask

  task automatic step(input logic [2:0] r, input logic [2:0] rl, input string tag);
    req = r;
    rel = rl;
    @(posedge clk);
    model_edge(r, rl);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input logic [2:0] r);
    reset = 1'b1;
    req   = r;
    rel   = '0;
    @(posedge clk);
    model_reset();
    #1;
    check_all("reset");
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset(3'b000);
    do_reset(3'b111);

    // Two grants from ptr=0, then release of requester 0 and rotation to requester 2.
    step(3'b111, 3'b000, "tp1");
    check("tp1.gnt_lit", 32'(gnt), 32'(3'b011));
    check("tp1.unit_lit", 32'(gnt_unit), 32'(3'b010));
    step(3'b111, 3'b001, "tp2");
    check("tp2.gnt_lit", 32'(gnt), 32'(3'b010));
    step(3'b111, 3'b000, "tp3");
    check("tp3.gnt_lit", 32'(gnt), 32'(3'b110));
    check("tp3.unit_lit", 32'(gnt_unit), 32'(3'b010));

    // Reset while both units busy, then a single request lands on unit 0.
    do_reset(3'b111);
    check("rst.gnt_lit", 32'(gnt), 32'(3'b000));
    step(3'b100, 3'b000, "after_rst");
    check("after_rst.gnt_lit", 32'(gnt), 32'(3'b100));
    check("after_rst.busy_lit", 32'(busy), 32'(2'b01));

    // Requester 1 alone: grant / release cycles.
    do_reset(3'b000);
    for (int i = 0; i < 4; i++) begin
      step(3'b010, 3'b000, "solo_hold");
      check("solo.gnt_lit", 32'(gnt), 32'(3'b010));
      step(3'b010, 3'b010, "solo_rel");
      check("solo.rel_lit", 32'(gnt), 32'(3'b000));
    end

    // Long hold by requester 0 with stray releases from non-owners.
    do_reset(3'b000);
    step(3'b001, 3'b000, "hold_grant");
    for (int i = 0; i < 100; i++) step(3'b001, (i % 7 == 3) ? 3'b110 : 3'b000, "hold");

    // Release landing exactly on the timeout cycle.
    do_reset(3'b000);
    step(3'b001, 3'b000, "edge_grant");
    for (int i = 0; i < int'(TMO) - 1; i++) step(3'b001, 3'b000, "edge_hold");
    step(3'b001, 3'b001, "edge_rel");
    check("edge_rel.tmo_lit", 32'(tmo), 32'(3'b000));
    check("edge_rel.gnt_lit", 32'(gnt), 32'(3'b000));

    // Random traffic with occasional reset.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset(3'($urandom));
      else step(3'($urandom), ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/la_arb3x2.md
# la_arb3x2

Round-robin arbiter that shares two identical resource units among three requesters. It grants a unit whenever any of the three requesters is pending and any of the two units is free, the OA32 condition (a0|a1|a2)&(b0|b1) made sequential. Ownership is held until the owner releases. It sits in front of shared stdlib-built datapath resources such as multipliers or memory ports, and sequences access to them.

## Interface
- PROP, "DEFAULT", implementation property string, passed through; no functional effect
- TIMEOUT, 16, hold limit in cycles, 2..65535; used only with LA_ARB3X2_TIMEOUT_EN
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset; synchronous and active-high
- req  in  3  request level per requester
- rel  in  3  release pulse per requester; ignored unless that requester holds a grant
- gnt  out  3  grant level per requester
- gnt_unit  out  3  unit owned by requester i (0/1); valid only while gnt[i]=1, 0 otherwise
- busy  out  2  unit k currently owned
- avail  out  1  registered (|pending)&(|~busy), where pending = req&~gnt
- tmo  out  3  one-cycle pulse: grant i was force-released by timeout

## Operation
- Reset (reset=1 at an edge) values: gnt=0, gnt_unit=0, busy=0, avail=0, tmo=0, round-robin pointer ptr=0, hold counters=0. Reset overrides all other activity, including mid-hold; every grant is dropped without a tmo pulse.
- Pending set: P = req & ~gnt. Free set: F = ~busy.
- Each cycle, pick up to min(|P|,|F|) requesters:
  - First pick: the first set bit of P scanning ptr, ptr+1, ptr+2 (mod 3). It takes the lowest-numbered free unit.
  - Second pick, if still free and pending: the next set bit after the first pick. It takes the remaining unit.
- ptr becomes (last granted index + 1) mod 3. ptr is unchanged when nothing is granted.
- Per-unit state machine, one per unit: IDLE -> BUSY on grant; BUSY -> IDLE on rel from the owner, or on timeout. No other transitions.
- A requester holds its grant until it releases it. A req drop while granted does not release the grant.
- A unit freed at edge n is not re-granted until the arbitration sampled at edge n+1. There is no same-cycle free-and-grant bypass.
- After release, the requester is pending again if req is still high. It competes fairly from the updated ptr.
- At most one unit per requester. At most two grants outstanding.

## Timing
- Grant latency 1 cycle: req high sampled at edge n gives gnt high after edge n.
- Release latency 1 cycle: rel sampled at edge n gives gnt and busy low after edge n. Earliest re-grant of that unit is after edge n+1.
- avail reflects state sampled at the previous edge. It is advisory only.
- Simultaneous cases:
  - Releases on both units in one cycle free both.
  - A release for requester i and a new request from requester j in the same cycle: the release is processed and j waits at least one cycle.
  - rel together with timeout on the same edge counts as a normal release; tmo stays 0.

## Configuration
- LA_ARB3X2_TIMEOUT_EN defined:
  - One 16-bit hold counter per unit. It clears on grant and increments while BUSY.
  - When the count reaches TIMEOUT-1 without rel, the unit returns to IDLE at the next edge. gnt[i] drops and tmo[i] pulses for one cycle.
- Not defined: no counters; units stay BUSY until rel; tmo tied to 0. The port list is identical in both builds.

## Structure
- Shared package la_arb3x2_pkg: unit state encoding (IDLE=0, BUSY=1), NREQ=3, NUNIT=2, counter width 16.
- One sub-module, la_arb3x2_pick: combinational rotate-priority picker. Takes P and ptr, returns the first and second pick indices with valid flags. The grant, release and timeout logic stays in the top.

## Test plan
- Reset then req=3'b111 -> after 1 cycle gnt=3'b011, gnt_unit[0]=0, gnt_unit[1]=1, busy=2'b11, ptr=2.
- rel=3'b001 with req still 3'b111 -> next cycle gnt=3'b010, busy=2'b10. Following cycle gnt=3'b110 with requester 2 on unit 0, ptr=0.
- Requester 1 alone requests, releases, and re-requests 4 times while requesters 0 and 2 are idle -> re-granted every 2 cycles, never starved, no spurious grants.
- reset asserted while both units BUSY -> next cycle all outputs 0, and req=3'b100 is then granted after 1 cycle on unit 0.
- TIMEOUT=4 with the macro defined, requester 0 holds without rel -> gnt[0] drops after 4 BUSY cycles, tmo=3'b001 for exactly one cycle. Without the macro, gnt holds for 100 cycles and tmo stays 0.
- rel asserted by a non-granted requester, and on the timeout cycle -> no state change, and tmo stays 0 respectively.
